// File: rtl/output_module_pkg.sv
// Shared definitions for the router output stage: direction codes,
// output FSM state type and small direction helpers.
`ifndef OUTPUT_MODULE_PKG_SV
`define OUTPUT_MODULE_PKG_SV
package output_module_pkg;

  // Direction codes shared with the input modules
  localparam logic [2:0] DIR_N       = 3'd0;
  localparam logic [2:0] DIR_S       = 3'd1;
  localparam logic [2:0] DIR_E       = 3'd2;
  localparam logic [2:0] DIR_W       = 3'd3;
  localparam logic [2:0] DIR_L       = 3'd4;
  localparam logic [2:0] DIR_INVALID = 3'd7;

  localparam int NUM_SRC = 5;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_READ    = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_SEND    = 2'd3
  } out_state_e;

  // One-hot strobe for a direction code; anything outside N..L yields no strobe
  function automatic logic [4:0] dir_onehot(input logic [2:0] code);
    logic [4:0] oh_s;
    oh_s = 5'b00000;
    case (code)
      DIR_N:   oh_s = 5'b00001;
      DIR_S:   oh_s = 5'b00010;
      DIR_E:   oh_s = 5'b00100;
      DIR_W:   oh_s = 5'b01000;
      DIR_L:   oh_s = 5'b10000;
      default: oh_s = 5'b00000;
    endcase
    return oh_s;
  endfunction

  // Source index reached by stepping 'step' places after 'ptr', wrapping 4 -> 0
  function automatic logic [2:0] wrap_idx(input logic [2:0] ptr, input int step);
    int sum_s;
    sum_s = (int'(ptr) + step) % NUM_SRC;
    return 3'(sum_s);
  endfunction

endpackage
`endif

// File: rtl/output_module_rr_arbiter.sv
// Five-way round-robin arbiter. The pointer remembers the last committed
// winner; the search starts one place after it. Shared with input-side arbitration.
module rr_arbiter
  import output_module_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] req,
  input  logic       advance,
  output logic [2:0] winner,
  output logic       valid
);

  logic [2:0] ptr_r;
  logic [2:0] winner_s;
  logic       valid_s;

  // Pick the first requesting source after the pointer in wrap-around order
  always_comb begin
    winner_s = DIR_INVALID;
    valid_s  = 1'b0;
    for (int i = 1; i <= NUM_SRC; i++) begin
      if (!valid_s && req[wrap_idx(ptr_r, i)]) begin
        winner_s = wrap_idx(ptr_r, i);
        valid_s  = 1'b1;
      end else begin
        valid_s  = valid_s;
      end
    end
  end

  // Move the pointer only when the consumer commits the current winner
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_r <= DIR_L;
    end else if (advance && valid_s) begin
      ptr_r <= winner_s;
    end else begin
      ptr_r <= ptr_r;
    end
  end

  assign winner = winner_s;
  assign valid  = valid_s;

endmodule

// File: rtl/output_module.sv
// Router output stage: arbitrates among the input VC buffers holding flits
// for this direction, reads one flit, registers it and writes it downstream.
module output_module
  import output_module_pkg::*;
#(
  parameter int         MSB_SLOT = 5,
  parameter int         DSIZE    = 1 << MSB_SLOT,
  parameter logic [2:0] PORT     = 3'b000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [4:0]         req_empty,
  input  logic [5*DSIZE-1:0] data_in,
  output logic [4:0]         read_en,
  input  logic               recv_full,
  output logic [DSIZE-1:0]   data_out,
  output logic               out_write,
  output logic [2:0]         grant
);

  // A flit never turns back the way it came, except at the local port
  localparam logic [4:0] REQ_MASK = (PORT == DIR_L) ? 5'b11111 : ~dir_onehot(PORT);

  out_state_e       state_r;
  logic [2:0]       grant_r;
  logic [4:0]       read_en_r;
  logic [DSIZE-1:0] data_out_r;

  logic [4:0]       req_s;
  logic             start_s;
  logic [2:0]       arb_winner_s;
  logic             arb_valid_s;
  logic [DSIZE-1:0] capture_s;

  assign req_s   = ~req_empty & REQ_MASK;
  assign start_s = (state_r == ST_IDLE) && (req_s != 5'b00000) && !recv_full;

  rr_arbiter u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (req_s),
    .advance (start_s),
    .winner  (arb_winner_s),
    .valid   (arb_valid_s)
  );

  // Select the granted source's data slice; an invalid grant selects zero
  always_comb begin
    capture_s = {DSIZE{1'b0}};
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant_r == 3'(i)) begin
        capture_s = data_in[i*DSIZE +: DSIZE];
      end else begin
        capture_s = capture_s;
      end
    end
  end

  // Output FSM: grant, read strobe, capture, then send under flow control
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      grant_r    <= DIR_INVALID;
      read_en_r  <= 5'b00000;
      data_out_r <= {DSIZE{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_s && arb_valid_s) begin
            grant_r   <= arb_winner_s;
            read_en_r <= dir_onehot(arb_winner_s);
            state_r   <= ST_READ;
          end else begin
            read_en_r <= 5'b00000;
            state_r   <= ST_IDLE;
          end
        end
        ST_READ: begin
          read_en_r <= 5'b00000;
          state_r   <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          data_out_r <= capture_s;
          state_r    <= ST_SEND;
        end
        ST_SEND: begin
          if (!recv_full) begin
            grant_r <= DIR_INVALID;
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_SEND;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          grant_r   <= DIR_INVALID;
          read_en_r <= 5'b00000;
        end
      endcase
    end
  end

  // The write strobe follows the downstream full flag in the same cycle
  assign out_write = (state_r == ST_SEND) && !recv_full;
  assign read_en   = read_en_r;
  assign data_out  = data_out_r;
  assign grant     = grant_r;

endmodule

// File: tb/tb_output_module.sv
// Self-checking bench: three output stages (PORT = E, L, N) against a
// transaction-timestamp model, plus directed literal checks.
module tb_output_module;

  localparam int DSIZE = 32;
  localparam int NI    = 3;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic [4:0]         re   [NI];
  logic [5*DSIZE-1:0] di   [NI];
  logic               rf   [NI];
  logic [4:0]         rd   [NI];
  logic [DSIZE-1:0]   dout [NI];
  logic               ow   [NI];
  logic [2:0]         gr   [NI];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  output_module #(.PORT(3'd2)) u_e (
    .clk(clk), .reset(reset), .req_empty(re[0]), .data_in(di[0]), .read_en(rd[0]),
    .recv_full(rf[0]), .data_out(dout[0]), .out_write(ow[0]), .grant(gr[0]));
  output_module #(.PORT(3'd4)) u_l (
    .clk(clk), .reset(reset), .req_empty(re[1]), .data_in(di[1]), .read_en(rd[1]),
    .recv_full(rf[1]), .data_out(dout[1]), .out_write(ow[1]), .grant(gr[1]));
  output_module #(.PORT(3'd0)) u_n (
    .clk(clk), .reset(reset), .req_empty(re[2]), .data_in(di[2]), .read_en(rd[2]),
    .recv_full(rf[2]), .data_out(dout[2]), .out_write(ow[2]), .grant(gr[2]));

  function automatic logic [2:0] port_of(input int k);
    case (k)
      0:       return 3'd2;
      1:       return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          cyc = 0;
  bit          m_live = 1'b0;
  bit          m_busy [NI];
  int          m_tg   [NI];
  logic [2:0]  m_grant[NI];
  logic [2:0]  m_ptr  [NI];
  logic [4:0]  m_rd   [NI];
  logic [31:0] m_dout [NI];

  task automatic model_step();
    logic [4:0] req;
    logic [4:0] mask;
    int w;
    int age;
    cyc = cyc + 1;
    if (reset) m_live = 1'b1;
    for (int k = 0; k < NI; k++) begin
      if (reset) begin
        m_busy[k] = 1'b0; m_grant[k] = 3'd7; m_rd[k] = 5'd0;
        m_dout[k] = 32'd0; m_ptr[k] = 3'd4;
      end else if (!m_busy[k]) begin
        mask = (port_of(k) == 3'd4) ? 5'b11111 : ~(5'b00001 << port_of(k));
        req = ~re[k] & mask;
        m_rd[k] = 5'd0;
        if (req != 5'd0 && !rf[k]) begin
          w = -1;
          for (int i = 1; i <= 5; i++)
            if (w < 0 && req[(int'(m_ptr[k]) + i) % 5]) w = (int'(m_ptr[k]) + i) % 5;
          m_ptr[k] = 3'(w); m_grant[k] = 3'(w); m_rd[k] = 5'b00001 << w;
          m_busy[k] = 1'b1; m_tg[k] = cyc;
        end
      end else begin
        age = cyc - m_tg[k];
        if (age == 1) m_rd[k] = 5'd0;
        else if (age == 2) m_dout[k] = di[k][int'(m_grant[k])*DSIZE +: DSIZE];
        else if (!rf[k]) begin m_busy[k] = 1'b0; m_grant[k] = 3'd7; end
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Per-cycle comparison of every instance against the model
  initial forever begin
    @(negedge clk);
    if (m_live) begin
      for (int k = 0; k < NI; k++) begin
        check($sformatf("grant[%0d]", k), 32'(gr[k]), 32'(m_grant[k]));
        check($sformatf("read_en[%0d]", k), 32'(rd[k]), 32'(m_rd[k]));
        check($sformatf("data_out[%0d]", k), dout[k], m_dout[k]);
        check($sformatf("out_write[%0d]", k), 32'(ow[k]),
              32'(m_busy[k] && (cyc - m_tg[k]) >= 2 && !rf[k]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_read(input int k, output bit seen);
    seen = 1'b0;
    for (int c = 0; c < 12 && !seen; c++) begin
      @(negedge clk);
      if (rd[k] != 5'd0) seen = 1'b1;
    end
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    int n;
    int cnt;
    bit seen;
    bit flag;
    logic [31:0] got[6];
    int exp_rr[6] = '{0, 1, 2, 3, 4, 0};

    for (int k = 0; k < NI; k++) begin re[k] = 5'b11111; di[k] = '0; rf[k] = 1'b0; end
    reset = 1'b1;
    repeat (2) tick();
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      check("rst_grant", 32'(gr[k]), 32'd7);
      check("rst_read_en", 32'(rd[k]), 32'd0);
      check("rst_out_write", 32'(ow[k]), 32'd0);
      check("rst_data_out", dout[k], 32'd0);
    end
    tick(); reset = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check("idle_grant", 32'(gr[1]), 32'd7);
      check("idle_strobes", {26'd0, rd[1], ow[1]}, 32'd0);
    end

    // PORT=E, single source N
    tick(); re[0] = 5'b11110; di[0][31:0] = 32'hDEADBEEF;
    repeat (2) @(negedge clk);
    check("e_read_en", 32'(rd[0]), 32'h1);
    check("e_grant", 32'(gr[0]), 32'd0);
    repeat (2) @(negedge clk);
    check("e_out_write", 32'(ow[0]), 32'd1);
    check("e_data_out", dout[0], 32'hDEADBEEF);
    tick(); re[0] = 5'b11111;
    repeat (3) tick();

    // PORT=L, all sources pending, RR order from reset
    reset = 1'b1; tick(); reset = 1'b0;
    re[1] = 5'b00000;
    for (int i = 0; i < 5; i++) di[1][i*DSIZE +: DSIZE] = 32'(i);
    n = 0;
    for (int c = 0; c < 40 && n < 6; c++) begin
      @(negedge clk);
      if (ow[1]) begin got[n] = dout[1]; n++; end
    end
    check("l_rr_count", 32'(n), 32'd6);
    for (int i = 0; i < n; i++) check($sformatf("l_rr_flit%0d", i), got[i], 32'(exp_rr[i]));
    tick(); re[1] = 5'b11111;
    repeat (5) tick();

    // PORT=N U-turn masked; PORT=L only local source
    re[2] = 5'b11110; re[1] = 5'b01111; di[1][4*DSIZE +: DSIZE] = 32'hCAFE0004;
    flag = 1'b0; seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (gr[2] != 3'd7 || rd[2] != 5'd0) flag = 1'b1;
      if (!seen && rd[1] != 5'd0) begin
        seen = 1'b1;
        check("l_bit4_grant", 32'(gr[1]), 32'd4);
        check("l_bit4_read_en", 32'(rd[1]), 32'h10);
      end
    end
    check("n_uturn_no_grant", 32'(flag), 32'd0);
    check("l_bit4_seen", 32'(seen), 32'd1);
    tick(); re[1] = 5'b11111; re[2] = 5'b11111;
    repeat (5) tick();

    // Backpressure while in SEND
    re[1] = 5'b11110; di[1][31:0] = 32'hA5A50001;
    wait_read(1, seen);
    check("bp_read_seen", 32'(seen), 32'd1);
    tick(); rf[1] = 1'b1; re[1] = 5'b11111;
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_hold_ow", 32'(ow[1]), 32'd0);
      check("bp_hold_data", dout[1], 32'hA5A50001);
    end
    tick(); rf[1] = 1'b0;
    cnt = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (ow[1]) cnt++;
    end
    check("bp_single_write", 32'(cnt), 32'd1);

    // Full downstream while idle with requests pending
    tick(); rf[1] = 1'b1; re[1] = 5'b00000;
    flag = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (rd[1] != 5'd0) flag = 1'b1;
    end
    check("full_idle_no_read", 32'(flag), 32'd0);
    tick(); re[1] = 5'b11111; rf[1] = 1'b0;
    repeat (3) tick();

    // Reset during CAPTURE
    re[1] = 5'b11011; di[1][2*DSIZE +: DSIZE] = 32'h12345678;
    wait_read(1, seen);
    check("rc_read_seen", 32'(seen), 32'd1);
    tick(); reset = 1'b1; re[1] = 5'b00000;
    @(negedge clk);
    tick(); reset = 1'b0;
    @(negedge clk);
    check("rc_grant", 32'(gr[1]), 32'd7);
    check("rc_data_out", dout[1], 32'd0);
    check("rc_strobes", {26'd0, rd[1], ow[1]}, 32'd0);
    wait_read(1, seen);
    check("rc_restart_seen", 32'(seen), 32'd1);
    check("rc_restart_grant", 32'(gr[1]), 32'd0);
    tick(); re[1] = 5'b11111;
    repeat (5) tick();

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      tick();
      for (int k = 0; k < NI; k++) begin
        re[k] = 5'($urandom) | 5'($urandom);
        rf[k] = ($urandom_range(0, 3) == 0);
        di[k] = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      end
      reset = ($urandom_range(0, 199) == 0);
    end
    tick(); reset = 1'b0;
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/output_module.md
Name: output_module

Overview:
Per-output-port stage directly downstream of the five input modules. It collects the VC buffers that hold flits destined for this output direction and round-robin arbitrates among them. It reads one flit from the winning buffer, registers it, and writes it into the downstream FIFO (neighbour router input or local sink). It honours that FIFO's full flag for flow control.

Parameters:
MSB_SLOT, 5, log2 of flit width
DSIZE, 1<<MSB_SLOT, flit width in bits (32)
PORT, 3'b000, direction code of this output port (N=0, S=1, E=2, W=3, L=4)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
req_empty  input  5  empty flag of the VC buffer for this direction in each input module; bit index = source direction code [L,W,E,S,N]
data_in  input  5*DSIZE  concatenated VC buffer outputs; slice i = source i
read_en  output  5  one-hot read strobe to the granted VC buffer
recv_full  input  1  downstream FIFO full
data_out  output  DSIZE  registered flit to the downstream FIFO
out_write  output  1  single-cycle write strobe to the downstream FIFO
grant  output  3  direction code of the current grant; 3'b111 (INVALID) when idle

Behaviour:
- One clock (clk); reset is synchronous and active-high. It is sampled only on the rising edge of clk.
- Reset values:
  - state = IDLE
  - read_en = 0
  - out_write = 0
  - data_out = 0
  - grant = 3'b111
  - RR pointer = 4, so the first search starts at N.
- Request vector: req = ~req_empty & mask.
  - mask clears bit PORT (no U-turn) unless PORT == L (4).
- FSM states: IDLE, READ, CAPTURE, SEND.
- IDLE:
  - If req != 0 and !recv_full: latch the winner into grant, update pointer = winner, go to READ.
  - Otherwise stay in IDLE.
- READ: read_en[grant] = 1 for exactly this cycle; go to CAPTURE. VC buffers present read data on the cycle after read_en.
- CAPTURE: data_out <= data_in slice [grant] at the end of the cycle; go to SEND.
- SEND:
  - out_write = !recv_full.
  - If !recv_full: go to IDLE, and grant returns to 3'b111 on the next cycle.
  - If recv_full: hold data_out and stay in SEND. out_write stays 0; the flit is neither dropped nor duplicated.
- Round-robin:
  - Search order starts at (pointer+1) mod 5 and wraps 4 -> 0.
  - The winner is the first set req bit in that order.
  - The pointer updates only on grant.
- Latency: a request seen in IDLE on cycle t gives read_en on t+1 and out_write on t+3 at the earliest. Throughput is 1 flit per 4 cycles per output.
- Stability: req bits sampled in IDLE cannot vanish before READ, because only this block reads those VC slices.
- Widths: data is passed through unmodified; no arithmetic on flits.
- Reset in any state:
  - Abandons the in-flight flit.
  - Outputs take their reset values on the next edge.
  - No read_en or out_write is asserted in the reset cycle's aftermath.
- Invariants:
  - read_en is never more than one-hot.
  - read_en is 0 outside READ.
  - out_write is 0 outside SEND.

Decomposition:
- Direction codes N/S/E/W/L/INVALID go in the shared defines header used by the input modules. Guard them against redefinition.
- Sub-module rr_arbiter:
  - Inputs: clk, reset, 5-bit req, advance strobe.
  - Outputs: 3-bit winner code plus a valid flag.
  - Holds the RR pointer.
  - Shared with the input-side arbitration.

Test Plan:
- Reset, then req_empty=5'b11111 for 20 cycles -> read_en=0, out_write=0, grant=3'b111 throughout.
- PORT=E, req_empty=5'b11110, data_in slice0=32'hDEADBEEF -> read_en=5'b00001 one cycle later; out_write=1 with data_out=32'hDEADBEEF 3 cycles after the request; grant=0.
- PORT=L, all five sources permanently non-empty, flit value = source index -> successive out_write flits carry 0,1,2,3,4,0 (RR order from reset).
- PORT=N, only req_empty[0]=0 -> no grant ever (U-turn masked). PORT=L with only bit 4 set -> grant=4.
- Flit captured, recv_full=1 for 5 cycles in SEND -> out_write=0, data_out held. recv_full drops -> exactly one out_write. recv_full=1 in IDLE with requests pending -> no read_en.
- reset=1 in the CAPTURE cycle -> next cycle IDLE, data_out=0, no out_write; the next grant starts the search at N.
